sevseg_decoder: RTL
===================

SEVSEG_DECODER -- requirements
Module: sevseg_decoder

Interface
REQ-001 The parameter SETTLE_CYC SHALL default to 2 and set the number of consecutive identical samples required before a digit is captured (legal range 1..15).
REQ-002 The parameter TIMEOUT_CYC SHALL default to 1024 and set the idle cycles after which a partial frame is discarded (legal range 16..65535).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 leds  input  7  SHALL be the active-low segment bus {g,f,e,d,c,b,a}, synchronous to clk.
REQ-006 Anode  input  4  SHALL be the active-low digit select, synchronous to clk.
REQ-007 min  output  6  SHALL be the decoded minutes value of the last good frame.
REQ-008 sec  output  6  SHALL be the decoded seconds value of the last good frame.
REQ-009 frame_valid  output  1  SHALL be a one-cycle pulse marking an update of min/sec.
REQ-010 seg_err  output  1  SHALL be a sticky flag for an undecodable or out-of-range frame.
REQ-011 stale  output  1  SHALL be a flag indicating a partial frame was discarded by timeout.

Function
REQ-012 Inputs {Anode,leds} SHALL be registered once; stability SHALL be judged by comparing the registered sample with the previous registered sample.
REQ-013 A stability counter SHALL reset to 0 on any sample change and increment, saturating at 15, while samples are equal.
REQ-014 Exactly one capture SHALL occur per stable window: on the cycle the sample has been unchanged for SETTLE_CYC consecutive samples.
REQ-015 Anode mapping: 0111 = minute tens (slot 3), 1011 = minute ones (slot 2), 1101 = second tens (slot 1), 1110 = second ones (slot 0).
REQ-016 Anode 1111 (blank) or any non-one-hot-low value SHALL produce no capture and SHALL NOT touch the frame state.
REQ-017 Segment decode SHALL be: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9; any other pattern, including 0111111, SHALL be invalid.
REQ-018 Each capture SHALL write the digit value and a per-slot valid bit into the slot; recapture of an already-filled slot SHALL overwrite it.
REQ-019 An invalid pattern SHALL mark the slot as filled-with-error.
REQ-020 FSM states SHALL be COLLECT and EMIT; COLLECT SHALL move to EMIT on the cycle after the capture that fills all four slots.
REQ-021 In EMIT, if no slot is in error and both tens digits are <= 5, min SHALL be set to tens*10+ones, sec likewise, and frame_valid SHALL pulse; otherwise seg_err SHALL be set and min/sec SHALL hold.
REQ-022 EMIT SHALL last one cycle, clear all slot bits, and return to COLLECT; a capture arriving during EMIT SHALL land in the cleared frame.
REQ-023 Arithmetic SHALL use 6-bit results; the maximum legal value SHALL be 59.
REQ-024 seg_err SHALL clear on the next frame_valid pulse.
REQ-025 Latency SHALL be frame_valid asserting two cycles after the capture cycle of the fourth slot.

Reset
REQ-026 When rst_n is asserted: min=0, sec=0, frame_valid=0, seg_err=0, stale=0, slots cleared, counters=0, and the FSM SHALL be in COLLECT.
REQ-027 Reset mid-frame SHALL discard all partial slots; no frame_valid SHALL be emitted for it after release.

Configuration
REQ-028 With SEVSEG_DEC_TIMEOUT_EN defined, an idle counter SHALL reset on every capture; on reaching TIMEOUT_CYC with at least one slot filled, slots SHALL be cleared and stale set, and stale SHALL clear on the next frame_valid.
REQ-029 Without SEVSEG_DEC_TIMEOUT_EN, no idle counter SHALL exist, partial frames SHALL be held indefinitely, and stale SHALL be tied to 0.

Verification
REQ-030 Scan 0111/3, 1011/2, 1101/0, 1110/4, each held 4 cycles -> min=32, sec=4, one frame_valid pulse, seg_err=0.
REQ-031 Slot 1 driven with 0111111 during a full scan -> seg_err=1, min/sec hold, no frame_valid; then a good 5,9,5,9 scan -> min=59, sec=59, seg_err=0.
REQ-032 Digit "7" in slot 3 (min tens) during a full scan -> seg_err=1, no frame_valid.
REQ-033 Each slot held for only 1 cycle with SETTLE_CYC=2 -> no capture, no frame_valid; Anode=1111 or 0011 inserted between digits -> frame still completes correctly.
REQ-034 Two slots captured, then idle 1024 cycles with SEVSEG_DEC_TIMEOUT_EN -> stale=1, slots cleared; without the macro -> stale=0 and the frame completes after the remaining two slots.
REQ-035 rst_n pulsed low after three slots -> all outputs 0; one further slot -> no frame_valid.

Source files
------------

// File: rtl/sevseg_decoder.sv
// sevseg_decoder: recovers a minutes/seconds value from a multiplexed,
// active-low, four-digit seven-segment scan (Anode select + leds segments).
// Optional feature macro: SEVSEG_DEC_TIMEOUT_EN discards a partial frame
// after TIMEOUT_CYC cycles without a capture and raises stale.
//
// state   | meaning
// COLLECT | filling digit slots from settled captures
// EMIT    | one cycle: validate the full frame, update outputs, clear slots
module sevseg_decoder #(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] leds,
  input  logic [3:0] Anode,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       stale
);

  typedef enum logic {COLLECT, EMIT} state_t;

  // Capture fires when the run of identical samples reaches SETTLE_CYC,
  // i.e. when SETTLE_CYC-1 consecutive equal comparisons have been seen.
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYC - 1);

  state_t          state;
  logic [10:0]     smp_q, smp_prev;
  logic [3:0]      stab_cnt, stab_nxt;
  logic            same;
  logic            slot_ok;
  logic [1:0]      slot;
  logic [3:0]      slot_oh;
  logic            dig_bad;
  logic [3:0]      dig_val;
  logic            cap, tmo, emit_ok;
  logic [3:0][3:0] digit;
  logic [3:0]      filled, bad;

  // Register the raw bus once and keep one previous sample for comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q    <= '0;
      smp_prev <= '0;
    end else begin
      smp_q    <= {Anode, leds};
      smp_prev <= smp_q;
    end
  end

  assign same     = (smp_q == smp_prev);
  assign stab_nxt = !same ? 4'd0 : (stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1;

  // Count consecutive equal samples, saturating at 15
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stab_cnt <= '0;
    else        stab_cnt <= stab_nxt;
  end

  // Map the active-low digit select to a slot; blank or multi-select is ignored
  always_comb begin
    slot_ok = 1'b1;
    slot    = 2'd0;
    case (smp_q[10:7])
      4'b0111: slot = 2'd3;
      4'b1011: slot = 2'd2;
      4'b1101: slot = 2'd1;
      4'b1110: slot = 2'd0;
      default: slot_ok = 1'b0;
    endcase
  end

  assign slot_oh = 4'b0001 << slot;

  // Decode active-low {g,f,e,d,c,b,a}; anything not a clean digit is invalid
  always_comb begin
    dig_bad = 1'b0;
    dig_val = 4'd0;
    case (smp_q[6:0])
      7'b1000000: dig_val = 4'd0;
      7'b1111001: dig_val = 4'd1;
      7'b0100100: dig_val = 4'd2;
      7'b0110000: dig_val = 4'd3;
      7'b0011001: dig_val = 4'd4;
      7'b0010010: dig_val = 4'd5;
      7'b0000010: dig_val = 4'd6;
      7'b1111000: dig_val = 4'd7;
      7'b0000000: dig_val = 4'd8;
      7'b0011000: dig_val = 4'd9;
      default:    dig_bad = 1'b1;
    endcase
  end

  assign cap     = slot_ok && (stab_nxt == SETTLE_M1);
  assign emit_ok = (bad == 4'b0000) && (digit[3] <= 4'd5) && (digit[1] <= 4'd5);

`ifdef SEVSEG_DEC_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] idle_cnt;

  // Cycles since the last capture, parked at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   idle_cnt <= '0;
    else if (cap)                 idle_cnt <= '0;
    else if (idle_cnt != TMO_LIM) idle_cnt <= idle_cnt + 16'd1;
  end

  assign tmo = (state == COLLECT) && (idle_cnt == TMO_LIM) && (filled != 4'b0000);

  // stale marks a discarded partial frame until the next good frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stale <= 1'b0;
    else if (tmo)                      stale <= 1'b1;
    else if (state == EMIT && emit_ok) stale <= 1'b0;
  end
`else
  assign tmo   = 1'b0;
  assign stale = 1'b0;
`endif

  // Frame FSM: slot bookkeeping, validation and registered outputs.
  // Slot clears are issued before the capture write so a capture arriving
  // during EMIT (or on a timeout cycle) lands in the fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      filled      <= '0;
      bad         <= '0;
      digit       <= '0;
      min         <= '0;
      sec         <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (!tmo && cap && ((filled | slot_oh) == 4'b1111)) state <= EMIT;
        end
        EMIT: begin
          state <= COLLECT;
          if (emit_ok) begin
            min         <= 6'd10 * {2'b00, digit[3]} + {2'b00, digit[2]};
            sec         <= 6'd10 * {2'b00, digit[1]} + {2'b00, digit[0]};
            frame_valid <= 1'b1;
            seg_err     <= 1'b0;
          end else begin
            seg_err <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
      if (state == EMIT || tmo) begin
        filled <= '0;
        bad    <= '0;
      end
      if (cap) begin
        filled[slot] <= 1'b1;
        bad[slot]    <= dig_bad;
        digit[slot]  <= dig_val;
      end
    end
  end

endmodule
